// File: rtl/adia_phase_sequencer_if.sv
// Operand handshake and per-stage power-clock bundle for adia_phase_sequencer.
// The hold_req backpressure input exists only when ADIA_HOLD_STRETCH_EN is defined.
interface adia_phase_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                    run;
  logic                    in_valid;
  logic                    in_ready;
  logic                    out_valid;
  logic                    busy;
  logic [NUM_STAGES-1:0]   clkpos;
  logic [NUM_STAGES-1:0]   clkneg;
  logic [2*NUM_STAGES-1:0] stage_phase;
`ifdef ADIA_HOLD_STRETCH_EN
  logic                    hold_req;

  modport master (
    output run, in_valid, hold_req,
    input  in_ready, out_valid, busy, clkpos, clkneg, stage_phase
  );
  modport slave (
    input  run, in_valid, hold_req,
    output in_ready, out_valid, busy, clkpos, clkneg, stage_phase
  );
`else
  modport master (
    output run, in_valid,
    input  in_ready, out_valid, busy, clkpos, clkneg, stage_phase
  );
  modport slave (
    input  run, in_valid,
    output in_ready, out_valid, busy, clkpos, clkneg, stage_phase
  );
`endif
endinterface

// File: rtl/adia_phase_sequencer.sv
// Four-phase (W/E/H/R) power-clock sequencer for a cascade of adiabatic stages, with
// staggered start-up/drain and operand tokens. Optional ADIA_HOLD_STRETCH_EN adds hold_req.
module adia_phase_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int PHASE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  adia_phase_sequencer_if.slave bus
);
  localparam int              CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int              LAST     = NUM_STAGES - 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {PH_W = 2'd0, PH_E = 2'd1, PH_H = 2'd2, PH_R = 2'd3} phase_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  phase_e                phase_q [NUM_STAGES];
  phase_e                phase_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] active_q, active_d;
  logic [NUM_STAGES-1:0] token_q, token_d;
  logic                  out_valid_q, out_valid_d;

  logic [NUM_STAGES-1:0] in_w, in_e, in_h, in_r, clkpos;
  logic [NUM_STAGES-1:0] rel, adv, frz, pred_go, pred_done, tok_pred;
  logic                  tick, hold_stall, tick_eff, in_ready, accept;

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      in_w[i]   = (phase_q[i] == PH_W);
      in_e[i]   = (phase_q[i] == PH_E);
      in_h[i]   = (phase_q[i] == PH_H);
      in_r[i]   = (phase_q[i] == PH_R);
      clkpos[i] = in_e[i] | in_h[i];
    end
  end

`ifdef ADIA_HOLD_STRETCH_EN
  // Consumer backpressure: keep the last stage in H while its result is unclaimed.
  assign hold_stall = bus.hold_req && active_q[LAST] && in_h[LAST] && token_q[LAST];
`else
  assign hold_stall = 1'b0;
`endif

  assign tick     = (state_q != IDLE) && (cnt_q == CNT_LAST);
  assign tick_eff = tick && !hold_stall;
  assign in_ready = (state_q == RUN) && tick_eff && in_w[0];
  assign accept   = bus.in_valid && in_ready;

  // Stage i may leave W only once stage i-1 is powered and in E; stage 0 is gated by RUN.
  // Stage i may park in W only once stage i-1 is parked; stage 0 parks when run is gone.
  assign pred_go   = {active_q[LAST-1:0] & in_e[LAST-1:0], state_q == RUN};
  assign pred_done = {~active_q[LAST-1:0], (state_q == DRAIN) || !bus.run};
  assign tok_pred  = {token_q[LAST-1:0], accept};

  assign rel = {NUM_STAGES{tick_eff}} & ~active_q & pred_go;
  assign adv = {NUM_STAGES{tick_eff}} & active_q;
  assign frz = adv & in_r & pred_done;

  // A token marks a stage holding operand data: picked up on W->E from its
  // predecessor (or from an accept), released when the stage recovers R->W.
  assign active_d    = (active_q | rel) & ~frz;
  assign token_d     = (token_q | ((rel | (adv & in_w)) & tok_pred)) & ~(adv & in_r);
  assign out_valid_d = adv[LAST] && in_e[LAST] && token_q[LAST];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    phase_d = phase_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (rel[i] || adv[i]) phase_d[i] = phase_e'(2'(phase_q[i] + 2'd1));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.run) state_d = RUN;
      RUN:     if (!bus.run) state_d = DRAIN;
      DRAIN:   if (active_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_q == IDLE || state_d == IDLE) cnt_d = '0;
    else if (tick)                          cnt_d = hold_stall ? cnt_q : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      active_q    <= '0;
      token_q     <= '0;
      out_valid_q <= 1'b0;
      // NOTE: the phase array is a handful of flops, not a RAM, so resetting it is cheap and required.
      for (int i = 0; i < NUM_STAGES; i++) phase_q[i] <= PH_W;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      token_q     <= token_d;
      out_valid_q <= out_valid_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    bus.stage_phase = '0;
    for (int i = 0; i < NUM_STAGES; i++) bus.stage_phase[2*i +: 2] = phase_q[i];
  end

  assign bus.clkpos    = clkpos;
  assign bus.clkneg    = ~clkpos;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
